// File: rtl/count_event_monitor.sv
// Observer for a loadable up/down counter: classifies each count transition,
// keeps sticky status flags, a saturating wrap counter and a tracked direction.
module count_event_monitor #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count,
  input  logic              cmp_en,
  input  logic [WIDTH-1:0]  cmp_value,
  input  logic [3:0]        irq_mask,
  input  logic [3:0]        irq_ack,
  output logic [3:0]        status,
  output logic              irq,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        dir
);

  typedef enum logic [1:0] {
    DIR_UNKNOWN = 2'b00,
    DIR_UP      = 2'b01,
    DIR_DOWN    = 2'b10,
    DIR_HOLD    = 2'b11
  } dir_t;

  localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [WIDTH-1:0]  prev;
  logic              primed;
  logic              first_cls;
  logic [3:0]        status_q, status_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  dir_t              dir_q, dir_d;

  logic is_hold, is_up, is_down, is_jump;
  logic wrap_up, wrap_down, cmp_hit;
  logic [3:0] events;

  always_comb begin
    is_hold   = (count == prev);
    is_up     = (count == prev + ONE);
    is_down   = (count == prev - ONE);
    is_jump   = !(is_hold || is_up || is_down);
    wrap_up   = is_up && (prev == CNT_MAX);
    wrap_down = is_down && (prev == '0);
    // The very first classified edge may match even if prev already equals the target.
    cmp_hit   = cmp_en && (count == cmp_value) && ((prev != cmp_value) || first_cls);
    events    = primed ? {is_jump, cmp_hit, wrap_down, wrap_up} : 4'b0000;
  end

  // Set wins over acknowledge on the same edge.
  always_comb begin
    status_d = (status_q & ~irq_ack) | events;
    wrap_d   = wrap_q;
    if ((events[0] || events[1]) && (wrap_q != WRAP_MAX))
      wrap_d = wrap_q + WRAP_W'(1);
  end

  always_comb begin
    dir_d = dir_q;
    if (primed) begin
      if (is_jump)      dir_d = DIR_UNKNOWN;
      else if (is_hold) dir_d = DIR_HOLD;
      else if (is_up)   dir_d = DIR_UP;
      else              dir_d = DIR_DOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev      <= '0;
      primed    <= 1'b0;
      first_cls <= 1'b0;
      status_q  <= 4'b0000;
      wrap_q    <= '0;
      dir_q     <= DIR_UNKNOWN;
    end else begin
      prev      <= count;
      primed    <= 1'b1;
      first_cls <= !primed;
      status_q  <= status_d;
      wrap_q    <= wrap_d;
      dir_q     <= dir_d;
    end
  end

  assign status   = status_q;
  assign wrap_cnt = wrap_q;
  assign dir      = dir_q;
  assign irq      = |(status_q & irq_mask);

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor; a second instance with WRAP_W=2
// observes the same count stream for the saturation check.
module tb_count_event_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count;
  logic       cmp_en;
  logic [3:0] cmp_value;
  logic [3:0] irq_mask;
  logic [3:0] irq_ack;
  logic [3:0] status;
  logic       irq;
  logic [7:0] wrap_cnt;
  logic [1:0] dir;
  logic [3:0] sat_status;
  logic       sat_irq;
  logic [1:0] sat_wrap_cnt;
  logic [1:0] sat_dir;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_event_monitor #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .count(count), .cmp_en(cmp_en), .cmp_value(cmp_value),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .status(status), .irq(irq),
    .wrap_cnt(wrap_cnt), .dir(dir)
  );

  count_event_monitor #(.WIDTH(4), .WRAP_W(2)) dut_sat (
    .clk(clk), .reset(reset), .count(count), .cmp_en(cmp_en), .cmp_value(cmp_value),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .status(sat_status), .irq(sat_irq),
    .wrap_cnt(sat_wrap_cnt), .dir(sat_dir)
  );

  task automatic step(input logic [3:0] c);
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; count = 4'd7; cmp_en = 1'b0; cmp_value = 4'd0;
    irq_mask = 4'b0000; irq_ack = 4'b0000;

    // reset / prime
    step(4'd7);
    step(4'd7);
    chk("rst_status", status, 4'b0000);
    chk("rst_irq", irq, 1'b0);
    chk("rst_wrap", wrap_cnt, 8'd0);
    chk("rst_dir", dir, 2'b00);
    reset = 1'b1;
    step(4'd7);
    chk("prime_status", status, 4'b0000);
    chk("prime_dir", dir, 2'b00);

    // up-wrap (7->13 is a jump, so bit 3 also sets but is masked out)
    irq_mask = 4'b0001;
    step(4'd13);
    chk("up_first_dir", dir, 2'b00);
    chk("up_first_status", status, 4'b1000);
    chk("up_first_irq", irq, 1'b0);
    step(4'd14);
    chk("up_dir", dir, 2'b01);
    step(4'd15);
    chk("up_pre_status", status, 4'b1000);
    step(4'd0);
    chk("upwrap_status", status, 4'b1001);
    chk("upwrap_irq", irq, 1'b1);
    chk("upwrap_cnt", wrap_cnt, 8'd1);
    chk("upwrap_dir", dir, 2'b01);
    step(4'd1);

    // down-wrap and ack collision
    irq_ack = 4'b1001;
    step(4'd2);
    chk("ack_all_status", status, 4'b0000);
    chk("ack_irq", irq, 1'b0);
    irq_ack = 4'b0000;
    step(4'd1);
    chk("down_dir", dir, 2'b10);
    step(4'd0);
    step(4'd15);
    chk("dnwrap_status", status, 4'b0010);
    chk("dnwrap_dir", dir, 2'b10);
    chk("dnwrap_cnt", wrap_cnt, 8'd2);
    step(4'd0);
    chk("wrap_again_cnt", wrap_cnt, 8'd3);
    irq_ack = 4'b0010;
    step(4'd15);
    chk("collide_status", status, 4'b0011);
    chk("collide_cnt", wrap_cnt, 8'd4);
    step(4'd15);
    chk("ack_clr_status", status, 4'b0001);
    chk("ack_hold_dir", dir, 2'b11);
    irq_ack = 4'b0000;

    // load jump and compare
    cmp_en = 1'b1; cmp_value = 4'd10; irq_ack = 4'b0001;
    step(4'd3);
    chk("jump3_status", status, 4'b1000);
    irq_ack = 4'b0000;
    step(4'd4);
    chk("jump4_dir", dir, 2'b01);
    step(4'd10);
    chk("cmp_jump_status", status, 4'b1100);
    chk("cmp_jump_dir", dir, 2'b00);
    irq_ack = 4'b0100;
    step(4'd10);
    chk("cmp_ack_status", status, 4'b1000);
    chk("cmp_hold_dir", dir, 2'b11);
    irq_ack = 4'b0000;
    step(4'd10);
    chk("cmp_norefire1", status, 4'b1000);
    step(4'd10);
    chk("cmp_norefire2", status, 4'b1000);
    irq_mask = 4'b0100;
    #1;
    chk("mask_cmp_irq", irq, 1'b0);
    irq_mask = 4'b1000;
    #1;
    chk("mask_jump_irq", irq, 1'b1);

    // saturation
    cmp_en = 1'b0; irq_mask = 4'b0000;
    reset = 1'b0;
    step(4'd14);
    chk("sat_rst_cnt", sat_wrap_cnt, 2'd0);
    reset = 1'b1;
    step(4'd14);
    for (int i = 0; i < 5; i++) begin
      step(4'd15);
      step(4'd0);
      step(4'd14);
    end
    chk("sat_cnt", sat_wrap_cnt, 2'd3);
    chk("nosat_cnt", wrap_cnt, 8'd5);

    // reset mid-run
    irq_ack = 4'b1111;
    step(4'd15);
    chk("pre_mid_status", status, 4'b0000);
    irq_ack = 4'b0000;
    step(4'd0);
    for (int v = 1; v <= 6; v++) step(4'(v));
    chk("mid_status", status, 4'b0001);
    chk("mid_dir", dir, 2'b01);
    reset = 1'b0;
    step(4'd7);
    chk("mid_rst_status", status, 4'b0000);
    chk("mid_rst_dir", dir, 2'b00);
    chk("mid_rst_wrap", wrap_cnt, 8'd0);
    reset = 1'b1;
    step(4'd8);
    chk("mid_prime_status", status, 4'b0000);
    chk("mid_prime_dir", dir, 2'b00);
    step(4'd9);
    chk("mid_resume_status", status, 4'b0000);
    chk("mid_resume_dir", dir, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
